// File: rtl/adc_capture_ctrl_pkg.sv
// adc_capture_ctrl_pkg
//   Shared definitions for the ADC capture controller: default sizing
//   constants, the controller state enumeration and a small state decode
//   helper used by the top level.
package adc_capture_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int PRE_N_DEF  = 8;
  localparam int POST_N_DEF = 24;
  localparam int DEPTH_DEF  = PRE_N_DEF + POST_N_DEF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFILL   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_READOUT   = 3'd4
  } cap_state_e;

  // True in the states that keep the ADC strobing and accept samples.
  function automatic logic is_capture(input cap_state_e st);
    logic res;
    case (st)
      ST_PREFILL, ST_WAIT_TRIG, ST_POST: res = 1'b1;
      default:                           res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_ring.sv
// capture_ring
//   Simple dual-port sample ring: synchronous write port, registered read
//   port. The read register only updates when rd_en is high, so the
//   output word holds while the consumer stalls. Contents are never reset.
//   Ports:
//     CLK_i    in   clock
//     wr_en    in   write strobe
//     wr_addr  in   write address
//     wr_data  in   write data
//     rd_en    in   read strobe (rd_data updates on the next edge)
//     rd_addr  in   read address
//     rd_data  out  registered read data
module capture_ring
  import adc_capture_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     CLK_i,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Synchronous write port.
  always_ff @(posedge CLK_i) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port, held while rd_en is low.
  always_ff @(posedge CLK_i) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
//   Triggered ADC capture: after arm_i, strobes the ADC, fills PRE_N
//   pre-trigger samples, waits for a sample above baseline+threshold,
//   captures POST_N samples (trigger included) and then streams the DEPTH
//   ring words out oldest first over a valid/ready interface.
//   Ports:
//     CLK_i        in   clock (rising edge)
//     RST_i        in   synchronous active-high reset
//     adc_data_i   in   ADC sample, valid the cycle after adc_cs_o
//     adc_cs_o     out  ADC chip-select / sample strobe
//     arm_i        in   start an acquisition (honoured in IDLE only)
//     abort_i      in   cancel acquisition or readout
//     baseline_i   in   pedestal
//     threshold_i  in   trigger height above pedestal
//     rd_data_o    out  readout word
//     rd_valid_o   out  readout word valid
//     rd_ready_i   in   downstream accepts
//     rd_last_o    out  final readout word
//     busy_o       out  not IDLE
//     trig_o       out  trigger sample is being written this cycle
//     evt_cnt_o    out  completed readouts (wraps)
module adc_capture_ctrl
  import adc_capture_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PRE_N  = PRE_N_DEF,
  parameter int POST_N = POST_N_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              CLK_i,
  input  logic              RST_i,
  input  logic [DATA_W-1:0] adc_data_i,
  output logic              adc_cs_o,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] baseline_i,
  input  logic [DATA_W-1:0] threshold_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              rd_last_o,
  output logic              busy_o,
  output logic              trig_o,
  output logic [15:0]       evt_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  cap_state_e        state_r, state_nxt_s;
  logic [CW-1:0]     smp_cnt_r, smp_cnt_nxt_s;
  logic [CW-1:0]     rd_cnt_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_addr_s;
  logic              cs_r, samp_vld_r, busy_r;
  logic              rd_valid_r, rd_last_r;
  logic [15:0]       evt_cnt_r;
  logic [DATA_W:0]   level_s;
  logic              abort_s, wr_en_s, trig_s, rd_en_s, xfer_s, last_xfer_s;

  // The ADC answers one cycle after the strobe; a sample that arrives once
  // capture has ended (pipeline tail) is dropped by the capture gate.
  assign abort_s     = abort_i && (state_r != ST_IDLE);
  assign wr_en_s     = samp_vld_r && is_capture(state_r) && !abort_i;
  // Sum kept one bit wider so a high pedestal cannot wrap into a low level.
  assign level_s     = {1'b0, baseline_i} + {1'b0, threshold_i};
  assign trig_s      = wr_en_s && (state_r == ST_WAIT_TRIG) && ({1'b0, adc_data_i} > level_s);
  assign xfer_s      = rd_valid_r && rd_ready_i;
  assign last_xfer_s = (state_r == ST_READOUT) && xfer_s && rd_last_r && !abort_i;
  // Fetch whenever the output slot is empty or being drained this cycle.
  assign rd_en_s     = (state_r == ST_READOUT) && !abort_i && (rd_cnt_r < CW'(DEPTH))
                       && (!rd_valid_r || rd_ready_i);
  assign rd_addr_s   = wr_ptr_r + rd_cnt_r[AW-1:0];

  assign adc_cs_o   = cs_r;
  assign busy_o     = busy_r;
  assign rd_valid_o = rd_valid_r;
  assign rd_last_o  = rd_last_r;
  assign evt_cnt_o  = evt_cnt_r;
  // Combinational so the pulse lines up with the cycle the sample is written.
  assign trig_o     = trig_s;

  // Next-state and per-phase sample counting.
  always_comb begin
    state_nxt_s   = state_r;
    smp_cnt_nxt_s = smp_cnt_r;
    if (abort_s) begin
      state_nxt_s   = ST_IDLE;
      smp_cnt_nxt_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arm_i) begin
            state_nxt_s   = ST_PREFILL;
            smp_cnt_nxt_s = '0;
          end else begin
            state_nxt_s   = ST_IDLE;
          end
        end
        ST_PREFILL: begin
          if (wr_en_s && (smp_cnt_r == CW'(PRE_N - 1))) begin
            state_nxt_s   = ST_WAIT_TRIG;
            smp_cnt_nxt_s = '0;
          end else if (wr_en_s) begin
            smp_cnt_nxt_s = smp_cnt_r + CW'(1);
          end else begin
            smp_cnt_nxt_s = smp_cnt_r;
          end
        end
        ST_WAIT_TRIG: begin
          // The trigger sample is the first post-trigger sample.
          if (trig_s) begin
            state_nxt_s   = ST_POST;
            smp_cnt_nxt_s = CW'(1);
          end else begin
            state_nxt_s   = ST_WAIT_TRIG;
          end
        end
        ST_POST: begin
          if (wr_en_s && (smp_cnt_r == CW'(POST_N - 1))) begin
            state_nxt_s   = ST_READOUT;
            smp_cnt_nxt_s = '0;
          end else if (wr_en_s) begin
            smp_cnt_nxt_s = smp_cnt_r + CW'(1);
          end else begin
            smp_cnt_nxt_s = smp_cnt_r;
          end
        end
        ST_READOUT: begin
          if (last_xfer_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_READOUT;
          end
        end
        default: begin
          state_nxt_s   = ST_IDLE;
          smp_cnt_nxt_s = '0;
        end
      endcase
    end
  end

  // Control state, strobe pipeline, write pointer and event counter.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_r    <= ST_IDLE;
      smp_cnt_r  <= '0;
      wr_ptr_r   <= '0;
      cs_r       <= 1'b0;
      samp_vld_r <= 1'b0;
      busy_r     <= 1'b0;
      evt_cnt_r  <= 16'd0;
    end else begin
      state_r    <= state_nxt_s;
      smp_cnt_r  <= smp_cnt_nxt_s;
      cs_r       <= is_capture(state_nxt_s);
      samp_vld_r <= cs_r;
      busy_r     <= (state_nxt_s != ST_IDLE);
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (last_xfer_s) begin
        evt_cnt_r <= evt_cnt_r + 16'd1;
      end
    end
  end

  // Readout slot: RAM read register feeds rd_data_o directly, valid/last
  // track which word currently sits in it.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      rd_cnt_r   <= '0;
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
    end else if ((state_r == ST_READOUT) && (state_nxt_s == ST_READOUT)) begin
      if (rd_en_s) begin
        rd_cnt_r   <= rd_cnt_r + CW'(1);
        rd_valid_r <= 1'b1;
        rd_last_r  <= (rd_cnt_r == CW'(DEPTH - 1));
      end else if (xfer_s) begin
        rd_valid_r <= 1'b0;
        rd_last_r  <= 1'b0;
      end
    end else begin
      rd_cnt_r   <= '0;
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
    end
  end

  capture_ring #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ring (
    .CLK_i   (CLK_i),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r),
    .wr_data (adc_data_i),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_o)
  );

endmodule
